ahb_cmd_master: RTL
===================

Name: ahb_cmd_master

Overview:
- Single-outstanding AHB-Lite initiator: the bus-master counterpart to our AHB SRAM/ROM responders.
- Converts a simple valid/ready command channel (from loader, debug UART bridge or test sequencer) into single NONSEQ AHB-Lite transfers.
- Returns read data and error status on a valid/ready response channel.
- Sits between a non-CPU requester and the AHB interconnect, so the on-chip RAM can be preloaded or inspected over the same bus the CM0 uses.

Parameters:
- AW, 32, AHB address width; HADDR and cmd_addr are AW bits.

Ports:
- HCLK  input  1  clock
- HRESETn  input  1  asynchronous active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  command accepted when cmd_valid&cmd_ready
- cmd_write  input  1  1=write, 0=read
- cmd_addr  input  AW  byte address
- cmd_size  input  2  0=byte, 1=halfword, 2=word, 3=illegal
- cmd_wdata  input  32  write data, already lane-placed by requester
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumed when rsp_valid&rsp_ready
- rsp_rdata  output  32  read data (0 for writes and errors)
- rsp_err  output  1  1=bus ERROR or illegal command
- HADDR  output  AW  AHB address
- HTRANS  output  2  IDLE=00 or NONSEQ=10 only
- HSIZE  output  3  {0,cmd_size}
- HWRITE  output  1  AHB write
- HWDATA  output  32  AHB write data
- HBURST  output  3  constant 000 (SINGLE)
- HPROT  output  4  constant 0011
- HMASTLOCK  output  1  constant 0
- HREADY  input  1  bus ready (transfer phase done)
- HRDATA  input  32  AHB read data
- HRESP  input  1  0=OKAY, 1=ERROR

Behaviour:
- Clocking and reset: one clock, HCLK; reset HRESETn is asynchronous, active-low. Reset forces state IDLE.
- Reset values: HTRANS=00, HADDR=0, HSIZE=0, HWRITE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. cmd_ready=1 once reset is released.
- Registered outputs: all AHB outputs and rsp_* are registered. cmd_ready is (state==IDLE).
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - cmd_ready=1.
  - On handshake, latch the command.
  - Illegal command (cmd_size=3, or address misaligned for its size: halfword with addr[0]=1, word with addr[1:0]!=0) -> RESP with rsp_err=1, rsp_rdata=0; no bus activity.
  - Legal command -> ADDR, driving HTRANS=10, HADDR, HSIZE and HWRITE from the latched command.
- ADDR:
  - Hold address-phase signals until HREADY=1 at a rising edge.
  - On that edge: HTRANS->00, HWDATA<=latched wdata (writes; unchanged for reads), go to DATA.
  - HADDR/HSIZE/HWRITE hold their last values after the address phase.
- DATA:
  - HWDATA held stable while HREADY=0.
  - On the first edge with HREADY=1: rsp_err<=HRESP; rsp_rdata<=HRDATA for OKAY reads, else 0; go to RESP.
  - Two-cycle ERROR response: HTRANS is already IDLE in the first ERROR cycle (HREADY=0), so nothing is cancelled. Completion is taken on the second cycle, where HREADY=1 and HRESP=1.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_err stable until rsp_ready=1.
  - On that edge: rsp_valid->0, go to IDLE.
  - A new command cannot be accepted in the same cycle.
- Latency:
  - Zero-wait-state bus: accept edge E0; ADDR drives during E0->E1; DATA during E1->E2; rsp_valid=1 after E2. Three cycles from accept to rsp_valid.
  - Each HREADY-low cycle in ADDR or DATA adds one cycle.
  - Back-to-back throughput is one transfer per 4 cycles minimum.
- Outstanding transfers: never more than one. HTRANS is never SEQ or BUSY.
- Reset mid-operation:
  - HTRANS returns to 00 asynchronously.
  - Any pending response is discarded: rsp_valid=0.
  - Any in-flight data phase is abandoned.

Test Plan:
- Write, zero wait: cmd write addr=0x20, size=2, wdata=0xDEADBEEF.
  - Required response: one cycle of HTRANS=10/HADDR=0x20/HWRITE=1, then HWDATA=0xDEADBEEF with HTRANS=00.
  - rsp_valid 3 cycles after accept with rsp_err=0, rsp_rdata=0.
- Read with waits: read addr=0x24, size=2; HREADY low 2 cycles in ADDR and 3 in DATA, HRDATA=0x12345678 on the completing cycle.
  - Address phase held 3 cycles; rsp_rdata=0x12345678 at 8 cycles after accept.
- ERROR response: read addr=0x100; responder returns HRESP=1/HREADY=0, then HRESP=1/HREADY=1.
  - HTRANS=00 throughout the error; rsp_err=1, rsp_rdata=0.
- Illegal commands: size=1 addr=0x3; size=2 addr=0x2; size=3 addr=0x0.
  - HTRANS stays 00; each gives rsp_err=1 one cycle after accept.
- Response backpressure: hold rsp_ready=0 for 5 cycles after a byte read of 0xA5.
  - rsp_valid and rsp_rdata=0x000000A5 stable; cmd_ready=0 during the hold; next command accepted only after the rsp handshake.
- Reset mid-transfer: assert HRESETn=0 while in DATA with HREADY=0.
  - HTRANS=00 and rsp_valid=0 immediately.
  - After release: cmd_ready=1 and a fresh write completes normally.

Source files
------------

// File: rtl/ahb_cmd_master.sv
// Single-outstanding AHB-Lite initiator: turns a valid/ready command channel into
// single NONSEQ transfers and returns read data / error status on a response channel.
module ahb_cmd_master #(
  parameter int unsigned AW = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [1:0]    cmd_size,
  input  logic [31:0]   cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic [2:0]    HSIZE,
  output logic          HWRITE,
  output logic [31:0]   HWDATA,
  output logic [2:0]    HBURST,
  output logic [3:0]    HPROT,
  output logic          HMASTLOCK,
  input  logic          HREADY,
  input  logic [31:0]   HRDATA,
  input  logic          HRESP
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [1:0]    r_htrans,    w_htrans_nxt;
  logic [AW-1:0] r_haddr,     w_haddr_nxt;
  logic [2:0]    r_hsize,     w_hsize_nxt;
  logic          r_hwrite,    w_hwrite_nxt;
  logic [31:0]   r_hwdata,    w_hwdata_nxt;
  logic [31:0]   r_wdata,     w_wdata_nxt;
  logic          r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0]   r_rsp_rdata, w_rsp_rdata_nxt;
  logic          r_rsp_err,   w_rsp_err_nxt;

  logic          w_cmd_ready;
  logic          w_accept;
  logic          w_illegal;

  assign w_cmd_ready = (r_state == S_IDLE);
  assign w_accept    = cmd_valid & w_cmd_ready;

  // Size 3 is never legal; halfword/word must be naturally aligned.
  assign w_illegal = (cmd_size == 2'd3)
                   | ((cmd_size == 2'd1) & cmd_addr[0])
                   | ((cmd_size == 2'd2) & (|cmd_addr[1:0]));

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_illegal ? S_RESP : S_ADDR;
      S_ADDR: if (HREADY)    w_state_nxt = S_DATA;
      S_DATA: if (HREADY)    w_state_nxt = S_RESP;
      S_RESP: if (rsp_ready) w_state_nxt = S_IDLE;
      default:               w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values for every registered output
  always_comb begin
    w_htrans_nxt    = r_htrans;
    w_haddr_nxt     = r_haddr;
    w_hsize_nxt     = r_hsize;
    w_hwrite_nxt    = r_hwrite;
    w_hwdata_nxt    = r_hwdata;
    w_wdata_nxt     = r_wdata;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_illegal) begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_rdata_nxt = 32'd0;
          end else begin
            w_htrans_nxt = HTRANS_NONSEQ;
            w_haddr_nxt  = cmd_addr;
            w_hsize_nxt  = {1'b0, cmd_size};
            w_hwrite_nxt = cmd_write;
            w_wdata_nxt  = cmd_wdata;
          end
        end
      end
      S_ADDR: begin
        if (HREADY) begin
          w_htrans_nxt = HTRANS_IDLE;
          if (r_hwrite) w_hwdata_nxt = r_wdata;
        end
      end
      S_DATA: begin
        // An ERROR's first cycle has HREADY=0, so completion waits for its second cycle.
        if (HREADY) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = HRESP;
          w_rsp_rdata_nxt = (!r_hwrite && !HRESP) ? HRDATA : 32'd0;
        end
      end
      S_RESP: begin
        if (rsp_ready) w_rsp_valid_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // Output / datapath registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_htrans    <= HTRANS_IDLE;
      r_haddr     <= '0;
      r_hsize     <= 3'd0;
      r_hwrite    <= 1'b0;
      r_hwdata    <= 32'd0;
      r_wdata     <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_htrans    <= w_htrans_nxt;
      r_haddr     <= w_haddr_nxt;
      r_hsize     <= w_hsize_nxt;
      r_hwrite    <= w_hwrite_nxt;
      r_hwdata    <= w_hwdata_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign HTRANS    = r_htrans;
  assign HADDR     = r_haddr;
  assign HSIZE     = r_hsize;
  assign HWRITE    = r_hwrite;
  assign HWDATA    = r_hwdata;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

endmodule
